axis_ram_burst_writer: RTL and testbench

//  Streams AXI4-Stream samples into DDR through an AXI3 write master, using bursts
//  of BURST_LEN beats. Generalises our fixed 16-beat writer: programmable burst length,

---
 rtl/axis_ram_burst_writer.sv | 134 +++++++++++++
 tb/tb_axis_ram_burst_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ram_burst_writer.sv
// axis_ram_burst_writer: AXI4-Stream to AXI3 burst write master with width-converting FWFT FIFO
module axis_ram_burst_writer #(
  parameter int ADDR_WIDTH       = 16,
  parameter int AXI_ID_WIDTH     = 6,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int FIFO_WRITE_DEPTH = 512,
  parameter int BURST_LEN        = 16,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int AXI_WRITE_ID     = 0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          cfg_enable,
  input  logic                          cfg_oneshot,
  input  logic [AXI_ADDR_WIDTH-1:0]     min_addr,
  input  logic [ADDR_WIDTH-1:0]         cfg_data,
  output logic [ADDR_WIDTH-1:0]         sts_data,
  output logic                          sts_done,
  output logic                          sts_overflow,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [3:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic [3:0]                    m_axi_awcache,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_wid,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready
);
  localparam int R = AXI_DATA_WIDTH / AXIS_TDATA_WIDTH;
  localparam int PW = $clog2(FIFO_WRITE_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(BURST_LEN * (AXI_DATA_WIDTH / 8));
  localparam logic [1:0] IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

  logic [AXIS_TDATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, fifo_beats;
  logic [1:0] state;
  logic [3:0] beat, outstanding;
  logic [ADDR_WIDTH-1:0] cfg_last;
  logic run, last_burst, full, push, pop, aw_hs, b_hs, start;

  assign full = count == (PW+1)'(FIFO_WRITE_DEPTH);
  assign fifo_beats = count >> $clog2(R);
  assign s_axis_tready = run & ~full;
  assign push = s_axis_tvalid & s_axis_tready;
  assign m_axi_wvalid = (state == BURST) & (fifo_beats != '0);
  assign pop = m_axi_wvalid & m_axi_wready;
  assign m_axi_wlast = m_axi_wvalid & (beat == 4'(BURST_LEN - 1));
  assign m_axi_bready = run;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign b_hs = m_axi_bvalid & m_axi_bready;
  // a new burst waits for the previous AW so sts_data and outstanding are settled
  assign start = (state == IDLE) & cfg_enable & ~m_axi_awvalid &
                 (fifo_beats >= (PW+1)'(BURST_LEN)) & (outstanding < 4'(MAX_OUTSTANDING));

  assign m_axi_awid = AXI_ID_WIDTH'(AXI_WRITE_ID);
  assign m_axi_wid = AXI_ID_WIDTH'(AXI_WRITE_ID);
  assign m_axi_awlen = 4'(BURST_LEN - 1);
  assign m_axi_awsize = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b1010;
  assign m_axi_wstrb = '1;

  for (genvar g = 0; g < R; g++) begin : g_rd
    assign m_axi_wdata[g*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH] = mem[rd_ptr + PW'(g)];
  end

  always_ff @(posedge aclk)
    if (push) mem[wr_ptr] <= s_axis_tdata;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      run <= 1'b0;
      state <= IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr <= '0;
      sts_data <= '0;
      sts_done <= 1'b0;
      sts_overflow <= 1'b0;
      outstanding <= '0;
      beat <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cfg_last <= '0;
      last_burst <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + PW'(R);
      count <= count + (PW+1)'(push) - (pop ? (PW+1)'(R) : '0);
      if (s_axis_tvalid & run & full) sts_overflow <= 1'b1;
      outstanding <= outstanding + 4'(aw_hs) - 4'(b_hs);
      if (pop) beat <= beat + 1'b1;
      if (aw_hs) begin
        m_axi_awvalid <= 1'b0;
        sts_data <= (sts_data < cfg_last) ? sts_data + 1'b1 : '0;
      end
      case (state)
        IDLE: if (start) begin
          state <= BURST;
          m_axi_awvalid <= 1'b1;
          m_axi_awaddr <= min_addr + STRIDE * AXI_ADDR_WIDTH'(sts_data);
          beat <= '0;
          cfg_last <= cfg_data;
          last_burst <= cfg_oneshot & (sts_data == cfg_data);
        end
        BURST: if (pop & m_axi_wlast) state <= last_burst ? DRAIN : IDLE;
        DRAIN: if (outstanding == '0 & ~m_axi_awvalid) begin
          state <= DONE;
          sts_done <= 1'b1;
        end
        default: if (!cfg_enable) begin
          state <= IDLE;
          sts_data <= '0;
          sts_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_ram_burst_writer.sv
// tb_axis_ram_burst_writer: scoreboard bench with a 4-beat, 2-outstanding, 16-deep writer
module tb_axis_ram_burst_writer;
  localparam int BL = 4;
  logic aclk = 0, aresetn = 0;
  logic cfg_enable = 0, cfg_oneshot = 0;
  logic [31:0] min_addr = 32'h0000_1000;
  logic [15:0] cfg_data = 0, sts_data;
  logic sts_done, sts_overflow;
  logic [5:0] awid, wid;
  logic [3:0] awlen, awcache;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [31:0] awaddr;
  logic awvalid, awready = 0;
  logic [7:0] wstrb;
  logic wlast, wvalid, wready = 0;
  logic [63:0] wdata;
  logic bvalid = 0, bready;
  logic [63:0] tdata = 0;
  logic tvalid = 0, tready;

  axis_ram_burst_writer #(.BURST_LEN(BL), .MAX_OUTSTANDING(2), .FIFO_WRITE_DEPTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot),
    .min_addr(min_addr), .cfg_data(cfg_data), .sts_data(sts_data), .sts_done(sts_done),
    .sts_overflow(sts_overflow), .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awcache(awcache), .m_axi_awaddr(awaddr),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_wid(wid), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_pass = 0;
  logic [31:0] exp_aw[$];
  logic [63:0] exp_w[$];
  int aw_cnt = 0, w_idx = 0, pend = 0, awv_cnt = 0, aw_delay = 0, seq = 0;
  bit b_en = 0, w_en = 0, w_toggle = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Slave-side responder: awready after aw_delay cycles, wready mode, one B per accepted AW
  initial forever begin
    bit aw_hs, b_hs;
    @(negedge aclk);
    aw_hs = awvalid & awready;
    b_hs = bvalid & bready;
    @(posedge aclk);
    #1;
    if (!aresetn) begin
      pend = 0;
      awv_cnt = 0;
    end else begin
      pend += int'(aw_hs) - int'(b_hs);
      awv_cnt = awvalid ? awv_cnt + 1 : 0;
    end
    awready = awvalid && awv_cnt > aw_delay;
    wready = w_toggle ? ~wready : w_en;
    bvalid = b_en && pend > 0;
  end

  // Monitor: pops the scoreboard on every AW / W handshake
  initial forever begin
    @(negedge aclk);
    if (!aresetn) w_idx = 0;
    else begin
      if (awvalid && awready) begin
        aw_cnt++;
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'(awaddr), 64'hx);
        else begin
          chk("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
          chk("awlen_size_burst_cache", {awlen, awsize, awburst, awcache}, {4'd3, 3'd3, 2'b01, 4'b1010});
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", wdata, 64'hx);
        else begin
          chk("wdata", wdata, exp_w.pop_front());
          chk("wlast", 64'(wlast), 64'(w_idx % BL == BL - 1));
        end
        w_idx++;
      end
    end
  end

  function automatic logic [63:0] word(int s);
    return {32'hDA7A_0000 | 32'(s), 32'(s) * 32'h0101_0101};
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic send(int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      tvalid = 1;
      tdata = word(seq);
      @(negedge aclk);
      while (!tready && t < 500) begin
        @(negedge aclk);
        t++;
      end
      if (t >= 500) chk("send_timeout", 0, 1);
      exp_w.push_back(word(seq));
      seq++;
      step(1);
    end
    tvalid = 0;
  endtask

  task automatic wait_idle(string nm);
    int t = 0;
    while (!(exp_aw.size() == 0 && pend == 0 && !awvalid && !wvalid) && t < 2000) begin
      step(1);
      t++;
    end
    if (t >= 2000) chk({nm, "_idle_timeout"}, 0, 1);
    step(3);
  endtask

  task automatic wait_aw(int target);
    int t = 0;
    while (aw_cnt < target && t < 200) begin
      step(1);
      t++;
    end
    if (t >= 200) chk("aw_wait_timeout", 64'(aw_cnt), 64'(target));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int base, acc;
    step(3);
    chk("rst_valids", {awvalid, wvalid, wlast, bready, tready}, 5'b0);
    chk("rst_status", {sts_data, sts_done, sts_overflow}, 18'b0);
    aresetn = 1;
    b_en = 1;
    w_en = 1;
    // circular, last index 3: five bursts wrap back to base
    cfg_data = 3;
    cfg_enable = 1;
    step(2);
    foreach (exp_aw[i]) exp_aw.delete(i);
    exp_aw = '{32'h1000, 32'h1020, 32'h1040, 32'h1060, 32'h1000};
    send(20);
    wait_idle("circ");
    chk("circ_sts_data", 64'(sts_data), 1);
    chk("circ_done_low", 64'(sts_done), 0);
    // one-shot, last index 1, B stalled: done only after both B responses
    aresetn = 0;
    step(1);
    aresetn = 1;
    b_en = 0;
    cfg_oneshot = 1;
    cfg_data = 1;
    base = aw_cnt;
    exp_aw = '{32'h1000, 32'h1020};
    send(12);
    wait_aw(base + 2);
    step(10);
    chk("oneshot_done_before_b", 64'(sts_done), 0);
    b_en = 1;
    wait_idle("oneshot");
    chk("oneshot_done", 64'(sts_done), 1);
    chk("oneshot_leftover_held", {wvalid, awvalid, tready}, 3'b001);
    chk("oneshot_sts_data", 64'(sts_data), 0);
    cfg_enable = 0;
    step(2);
    chk("done_cleared", 64'(sts_done), 0);
    // outstanding limit 2: third AW waits for a B
    b_en = 0;
    cfg_oneshot = 0;
    cfg_data = 7;
    base = aw_cnt;
    exp_aw = '{32'h1000, 32'h1020, 32'h1040};
    cfg_enable = 1;
    send(8);
    step(40);
    chk("max_out_aw_count", 64'(aw_cnt - base), 2);
    b_en = 1;
    step(1);
    b_en = 0;
    step(10);
    chk("third_aw_after_b", 64'(aw_cnt - base), 3);
    b_en = 1;
    wait_idle("maxout");
    chk("maxout_sts_data", 64'(sts_data), 3);
    // toggling wready, awready 10 cycles late
    w_toggle = 1;
    aw_delay = 10;
    exp_aw = '{32'h1060, 32'h1080};
    send(8);
    wait_idle("toggle");
    chk("toggle_sts_data", 64'(sts_data), 5);
    // overflow with W blocked
    w_toggle = 0;
    w_en = 0;
    aw_delay = 0;
    step(2);
    exp_aw = '{32'h10A0};
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      tvalid = 1;
      tdata = word(seq);
      @(negedge aclk);
      if (tready) begin
        acc++;
        seq++;
      end
      step(1);
    end
    tvalid = 0;
    chk("fifo_capacity", 64'(acc), 16);
    chk("full_tready", 64'(tready), 0);
    chk("overflow_set", 64'(sts_overflow), 1);
    chk("overflow_sts_data", 64'(sts_data), 6);
    aresetn = 0;
    step(1);
    exp_w.delete();
    chk("rst2_valids", {awvalid, wvalid, bready, tready}, 4'b0);
    chk("rst2_status", {sts_data, sts_done, sts_overflow}, 18'b0);
    aresetn = 1;
    step(2);
    chk("rst2_fifo_empty", {wvalid, tready}, 2'b01);
    // reset while a burst is stalled mid-way, then restart at base
    cfg_data = 3;
    base = aw_cnt;
    exp_aw = '{32'h1000};
    send(4);
    wait_aw(base + 1);
    step(2);
    chk("midburst_wvalid", 64'(wvalid), 1);
    aresetn = 0;
    step(1);
    chk("midburst_rst_valids", {awvalid, wvalid, wlast}, 3'b0);
    exp_w.delete();
    aresetn = 1;
    w_en = 1;
    exp_aw = '{32'h1000};
    send(4);
    wait_idle("restart");
    chk("restart_sts_data", 64'(sts_data), 1);
    chk("scoreboard_drained", 64'(exp_w.size() + exp_aw.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
